// File: rtl/uart_word_pkg.sv
// Shared constants, byte-FSM state encoding and the parity helper for the
// word-reassembling UART receiver.
package uart_word_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Parity bit a transmitter would send for this data byte.
  function automatic logic calc_parity(input logic [7:0] data, input logic [1:0] mode);
    logic p;
    p = 1'b0;
    case (mode)
      PAR_EVEN: p = ^data;
      PAR_ODD:  p = ~(^data);
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_word_rx_byte.sv
// Single-byte UART deserialiser: input synchroniser, start/data/parity/stop
// FSM. Result strobes are asserted in the stop-bit sample cycle.
module uart_rx_byte
  import uart_word_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       par_fail_o,
  output logic       frame_fail_o,
  output rx_state_e  state_o
);

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [1:0]     PAR_MODE  = 2'(PARITY);

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_bit_q, par_bit_d;
  logic          fall;
  logic          tick;

  assign fall    = rx_prev_q & ~rx_sync_q;
  assign tick    = (cnt_q == FULL_LAST);
  assign byte_o  = shift_q;
  assign state_o = state_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;
    byte_valid_o = 1'b0;
    par_fail_o   = 1'b0;
    frame_fail_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (fall) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A line that is high again at mid-start-bit was only a glitch.
          state_d = rx_sync_q ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (tick) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_PARITY: begin
        if (tick) begin
          cnt_d     = '0;
          par_bit_d = rx_sync_q;
          state_d   = ST_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (rx_sync_q) begin
            byte_valid_o = 1'b1;
            par_fail_o   = (PAR_MODE != PAR_NONE) &&
                           (par_bit_q != calc_parity(shift_q, PAR_MODE));
          end else begin
            frame_fail_o = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
    end
  end

endmodule

// File: rtl/uart_word_rx.sv
// UART receiver packing BYTES_PER_WORD bytes (first byte in the MSBs) into a
// word with ack handshake and overrun flag. UART_RX_TIMEOUT_EN adds a
// partial-word idle timeout.
module uart_word_rx
  import uart_word_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 434,
  parameter int BYTES_PER_WORD = 4,
  parameter int PARITY         = 1,
  parameter int TIMEOUT_BITS   = 20
) (
  input  logic                        CLK,
  input  logic                        CLR,
  input  logic                        Rx,
  input  logic                        Final_Data_Ack,
  output logic [7:0]                  Data_Rx,
  output logic                        Data_Ready,
  output logic [8*BYTES_PER_WORD-1:0] Final_Data,
  output logic                        Final_Data_Ready,
  output logic                        parity_err,
  output logic                        frame_err,
  output logic                        word_drop,
  output logic                        overrun,
  output logic [2:0]                  dbg_state
);

  localparam int           W  = 8 * BYTES_PER_WORD;
  localparam int           BW = $clog2(BYTES_PER_WORD + 1);
  localparam logic [BW-1:0] LAST_CNT = BW'(BYTES_PER_WORD);

  if (CLKS_PER_BIT < 8 || BYTES_PER_WORD < 1 || BYTES_PER_WORD > 16 ||
      PARITY < 0 || PARITY > 2 || TIMEOUT_BITS < 1) begin : g_bad_param
    $error("uart_word_rx: parameter out of range");
  end

  logic [7:0] rx_byte;
  logic       byte_valid, par_fail, frame_fail;
  rx_state_e  byte_state;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .PARITY       (PARITY)
  ) u_byte (
    .clk          (CLK),
    .rst_n        (CLR),
    .rx           (Rx),
    .byte_o       (rx_byte),
    .byte_valid_o (byte_valid),
    .par_fail_o   (par_fail),
    .frame_fail_o (frame_fail),
    .state_o      (byte_state)
  );

  assign dbg_state = byte_state;

  logic [W-1:0]  word_q, word_d, word_next;
  logic [BW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          pend_q, pend_d, pend_next;
  logic [W-1:0]  final_q, final_d;
  logic          fdr_q, fdr_d;
  logic          perr_q, perr_d;
  logic          ovr_q, ovr_d;
  logic [7:0]    data_rx_q, data_rx_d;
  logic          drdy_q, drdy_d;
  logic          ferr_q, ferr_d;
  logic          wdrop_q, wdrop_d;

`ifdef UART_RX_TIMEOUT_EN
  localparam int           TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int           TW       = $clog2(TO_LIMIT);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_LIMIT - 1);
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
`endif

  assign cnt_inc   = cnt_q + BW'(1);
  assign word_next = (word_q << 8) | W'(rx_byte);
  assign pend_next = pend_q | par_fail;

  // Handshake: Final_Data_Ready stays high until Final_Data_Ack is sampled
  // with it high; Ack while Final_Data_Ready is low has no effect.
  always_comb begin
    word_d    = word_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    final_d   = final_q;
    fdr_d     = fdr_q;
    perr_d    = perr_q;
    ovr_d     = ovr_q;
    data_rx_d = data_rx_q;
    drdy_d    = byte_valid;
    ferr_d    = frame_fail;
    wdrop_d   = 1'b0;

    if (fdr_q && Final_Data_Ack) begin
      fdr_d = 1'b0;
      ovr_d = 1'b0;
    end

    if (byte_valid) begin
      data_rx_d = rx_byte;
      if (cnt_inc == LAST_CNT) begin
        word_d = '0;
        cnt_d  = '0;
        pend_d = 1'b0;
        if (!fdr_q || Final_Data_Ack) begin
          final_d = word_next;
          perr_d  = pend_next;
          fdr_d   = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end else begin
        word_d = word_next;
        cnt_d  = cnt_inc;
        pend_d = pend_next;
      end
    end else if (frame_fail) begin
      wdrop_d = (cnt_q != '0);
      word_d  = '0;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end

`ifdef UART_RX_TIMEOUT_EN
    idle_cnt_d = '0;
    if (cnt_q != '0 && byte_state == ST_IDLE) begin
      if (idle_cnt_q == TO_LAST) begin
        wdrop_d = 1'b1;
        word_d  = '0;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end else begin
        idle_cnt_d = idle_cnt_q + TW'(1);
      end
    end
`endif
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      word_q    <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      final_q   <= '0;
      fdr_q     <= 1'b0;
      perr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      data_rx_q <= '0;
      drdy_q    <= 1'b0;
      ferr_q    <= 1'b0;
      wdrop_q   <= 1'b0;
    end else begin
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      final_q   <= final_d;
      fdr_q     <= fdr_d;
      perr_q    <= perr_d;
      ovr_q     <= ovr_d;
      data_rx_q <= data_rx_d;
      drdy_q    <= drdy_d;
      ferr_q    <= ferr_d;
      wdrop_q   <= wdrop_d;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) idle_cnt_q <= '0;
    else      idle_cnt_q <= idle_cnt_d;
  end
`endif

  assign Data_Rx          = data_rx_q;
  assign Data_Ready       = drdy_q;
  assign Final_Data       = final_q;
  assign Final_Data_Ready = fdr_q;
  assign parity_err       = perr_q;
  assign frame_err        = ferr_q;
  assign word_drop        = wdrop_q;
  assign overrun          = ovr_q;

endmodule

// File: tb/tb_uart_word_rx.sv
// Self-checking bench for uart_word_rx (CLKS_PER_BIT=16, even parity, 4-byte
// words); covers both builds of UART_RX_TIMEOUT_EN.
module tb_uart_word_rx;

  localparam int CPB = 16;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        Rx = 1'b1;
  logic        Final_Data_Ack = 1'b0;
  logic [7:0]  Data_Rx;
  logic        Data_Ready;
  logic [31:0] Final_Data;
  logic        Final_Data_Ready;
  logic        parity_err;
  logic        frame_err;
  logic        word_drop;
  logic        overrun;
  logic [2:0]  dbg_state;

  uart_word_rx #(
    .CLKS_PER_BIT   (CPB),
    .BYTES_PER_WORD (4),
    .PARITY         (1),
    .TIMEOUT_BITS   (20)
  ) dut (
    .CLK              (CLK),
    .CLR              (CLR),
    .Rx               (Rx),
    .Final_Data_Ack   (Final_Data_Ack),
    .Data_Rx          (Data_Rx),
    .Data_Ready       (Data_Ready),
    .Final_Data       (Final_Data),
    .Final_Data_Ready (Final_Data_Ready),
    .parity_err       (parity_err),
    .frame_err        (frame_err),
    .word_drop        (word_drop),
    .overrun          (overrun),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_drdy   = 0;
  int n_ferr   = 0;
  int n_wdrop  = 0;
  logic [7:0]  exp_byte_q[$];
  logic [32:0] exp_q[$];   // {parity_err, Final_Data}
  logic fdr_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (CLR) begin
      if (Data_Ready) begin
        n_drdy++;
        if (exp_byte_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL data_rx_unexpected: got %0h expected no byte", Data_Rx);
        end else begin
          check("data_rx", Data_Rx, exp_byte_q.pop_front());
        end
      end
      if (frame_err) n_ferr++;
      if (word_drop) n_wdrop++;
      if (Final_Data_Ready && !fdr_prev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL word_unexpected: got %0h expected no word", Final_Data);
        end else begin
          check("final_word", {parity_err, Final_Data}, exp_q.pop_front());
        end
      end
    end
    fdr_prev = Final_Data_Ready;
  end

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic v);
    Rx = v;
    repeat (CPB) @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic flip_par, input logic stop_v);
    if (stop_v) exp_byte_q.push_back(b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit((^b) ^ flip_par);
    drive_bit(stop_v);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [3:0] flip);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], flip[3-i], 1'b1);
  endtask

  task automatic wait_fdr(input string name);
    int k;
    k = 0;
    while (!Final_Data_Ready && k < 200) begin
      @(negedge CLK);
      k++;
    end
    check(name, Final_Data_Ready, 1'b1);
  endtask

  task automatic ack_word();
    Final_Data_Ack = 1'b1;
    @(negedge CLK);
    Final_Data_Ack = 1'b0;
    check("fdr_after_ack", Final_Data_Ready, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_rx"}, Data_Rx, 8'h00);
    check({tag, "_data_ready"}, Data_Ready, 1'b0);
    check({tag, "_final_data"}, Final_Data, 32'h0);
    check({tag, "_fdr"}, Final_Data_Ready, 1'b0);
    check({tag, "_parity_err"}, parity_err, 1'b0);
    check({tag, "_frame_err"}, frame_err, 1'b0);
    check({tag, "_word_drop"}, word_drop, 1'b0);
    check({tag, "_overrun"}, overrun, 1'b0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0] bytes;
    logic [3:0]  flip;      // bit 3 = first byte sent
    logic [31:0] exp_word;
    logic        exp_perr;
  } vec_t;

  localparam int NV = 6;
  vec_t vec[NV];

  initial begin
    int d0, f0, w0;
    logic [31:0] r;

    vec[0] = '{32'hABACADAE, 4'b0000, 32'hABACADAE, 1'b0};
    vec[1] = '{32'hABACADAE, 4'b0100, 32'hABACADAE, 1'b1};
    vec[2] = '{32'hABACADAE, 4'b0000, 32'hABACADAE, 1'b0};
    vec[3] = '{32'h00FF5501, 4'b0001, 32'h00FF5501, 1'b1};
    r = $urandom;
    vec[4] = '{r, 4'b0000, r, 1'b0};
    r = $urandom;
    vec[5] = '{r, 4'b1000, r, 1'b1};

    // Reset state
    repeat (4) @(negedge CLK);
    check_all_zero("reset");
    CLR = 1'b1;
    repeat (2 * CPB) @(negedge CLK);

    // Table: clean and parity-flipped words, held until ack
    for (int i = 0; i < NV; i++) begin
      d0 = n_drdy;
      exp_q.push_back({vec[i].exp_perr, vec[i].exp_word});
      send_word(vec[i].bytes, vec[i].flip);
      wait_fdr("fdr_rise");
      repeat (20) @(negedge CLK);
      check("fdr_held", Final_Data_Ready, 1'b1);
      check("drdy_count", n_drdy - d0, 4);
      ack_word();
      repeat ($urandom_range(1, 2 * CPB)) @(negedge CLK);
    end

    // Framing error on the third byte drops the partial word
    f0 = n_ferr;
    w0 = n_wdrop;
    send_byte(8'hAB, 1'b0, 1'b1);
    send_byte(8'hAC, 1'b0, 1'b1);
    send_byte(8'hAD, 1'b0, 1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("ferr_count", n_ferr - f0, 1);
    check("wdrop_frame", n_wdrop - w0, 1);
    check("no_word_after_ferr", Final_Data_Ready, 1'b0);
    exp_q.push_back({1'b0, 32'hABACADAE});
    send_word(32'hABACADAE, 4'b0000);
    wait_fdr("fdr_after_ferr");
    ack_word();

    // Overrun: second word lost, first kept
    exp_q.push_back({1'b0, 32'hABACADAE});
    send_word(32'hABACADAE, 4'b0000);
    wait_fdr("ovr_first");
    send_word(32'h11223344, 4'b0000);
    repeat (4) @(negedge CLK);
    check("ovr_keep_word", Final_Data, 32'hABACADAE);
    check("overrun_set", overrun, 1'b1);
    check("ovr_fdr_held", Final_Data_Ready, 1'b1);
    ack_word();
    check("overrun_clear", overrun, 1'b0);
    drive_bit(1'b1);

    // Inter-byte idle gap
    w0 = n_wdrop;
    send_byte(8'hAB, 1'b0, 1'b1);
    send_byte(8'hAC, 1'b0, 1'b1);
    repeat (21) drive_bit(1'b1);
`ifdef UART_RX_TIMEOUT_EN
    check("wdrop_timeout", n_wdrop - w0, 1);
    exp_q.push_back({1'b0, 32'hABACADAE});
    send_word(32'hABACADAE, 4'b0000);
`else
    check("wdrop_no_timeout", n_wdrop - w0, 0);
    exp_q.push_back({1'b0, 32'hABACABAC});
    send_byte(8'hAB, 1'b0, 1'b1);
    send_byte(8'hAC, 1'b0, 1'b1);
`endif
    wait_fdr("fdr_after_gap");
    ack_word();

    // Short low glitch is a false start
    d0 = n_drdy;
    f0 = n_ferr;
    Rx = 1'b0;
    repeat (4) @(negedge CLK);
    Rx = 1'b1;
    repeat (3 * CPB) @(negedge CLK);
    check("glitch_no_byte", n_drdy - d0, 0);
    check("glitch_no_ferr", n_ferr - f0, 0);
    check("glitch_state_idle", dbg_state, 3'd0);

    // Reset mid-word and mid-frame
    send_byte(8'hAB, 1'b0, 1'b1);
    send_byte(8'hAC, 1'b0, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    CLR = 1'b0;
    @(negedge CLK);
    check_all_zero("midreset");
    Rx = 1'b1;
    repeat (4) @(negedge CLK);
    CLR = 1'b1;
    repeat (2 * CPB) @(negedge CLK);
    exp_q.push_back({1'b0, 32'hABACADAE});
    send_word(32'hABACADAE, 4'b0000);
    wait_fdr("fdr_after_reset");
    ack_word();

    // ---------------- final report ----------------
    repeat (2 * CPB) @(negedge CLK);
    check("byte_queue_empty", exp_byte_q.size(), 0);
    check("word_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
